// File: rtl/registro_universal_param.sv
// N-bit universal register: hold/load/shift/rotate/arithmetic shift/clear, plus
// sequential multi-step shifts under start/busy/done. Define REG_PARITY_EN to add par/zero outputs.
module registro_universal_param #(
    parameter int           N       = 8,
    parameter logic [N-1:0] RST_VAL = '0,
    localparam int          AW      = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    op,
    input  logic [N-1:0]  d,
    input  logic          sin,
    input  logic          start,
    input  logic [AW-1:0] amt,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done,
`ifdef REG_PARITY_EN
    output logic          par,
    output logic          zero,
`endif
    output logic [1:0]    dbg_state
);

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_q, w_q_nxt;
    logic          r_sout, w_sout_nxt;
    logic [AW-1:0] r_count, w_count_nxt;
    logic [2:0]    r_op, w_op_nxt;

    logic [2:0]    w_step_op;
    logic [N-1:0]  w_step_q;
    logic          w_step_out;
    logic          w_is_shift;

    // One shift/rotate step; in RUN it uses the latched op so the live op input is ignored.
    always_comb begin
        w_step_op  = (r_state == ST_RUN) ? r_op : op;
        w_step_q   = r_q;
        w_step_out = r_sout;
        case (w_step_op)
            OP_SHL: begin w_step_q = {r_q[N-2:0], sin};      w_step_out = r_q[N-1]; end
            OP_SHR: begin w_step_q = {sin, r_q[N-1:1]};      w_step_out = r_q[0];   end
            OP_ROL: begin w_step_q = {r_q[N-2:0], r_q[N-1]}; w_step_out = r_q[N-1]; end
            OP_ROR: begin w_step_q = {r_q[0], r_q[N-1:1]};   w_step_out = r_q[0];   end
            OP_ASR: begin w_step_q = {r_q[N-1], r_q[N-1:1]}; w_step_out = r_q[0];   end
            default: ;
        endcase
    end

    assign w_is_shift = (op >= OP_SHL) && (op <= OP_ASR);

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_sout_nxt  = r_sout;
        w_count_nxt = r_count;
        w_op_nxt    = r_op;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    if (start && w_is_shift) begin
                        // The first step happens on the next edge, so q is untouched here.
                        w_op_nxt    = op;
                        w_count_nxt = amt;
                        w_state_nxt = (amt == '0) ? ST_DONE : ST_RUN;
                    end else begin
                        case (op)
                            OP_HOLD: ;
                            OP_LOAD: w_q_nxt = d;
                            OP_CLR:  w_q_nxt = RST_VAL;
                            default: begin
                                w_q_nxt    = w_step_q;
                                w_sout_nxt = w_step_out;
                            end
                        endcase
                    end
                end
            end
            ST_RUN: begin
                w_q_nxt     = w_step_q;
                w_sout_nxt  = w_step_out;
                w_count_nxt = r_count - AW'(1);
                if (r_count == AW'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= RST_VAL;
            r_sout  <= 1'b0;
            r_count <= '0;
            r_op    <= OP_HOLD;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_sout  <= w_sout_nxt;
            r_count <= w_count_nxt;
            r_op    <= w_op_nxt;
        end
    end

    assign q         = r_q;
    assign sout      = r_sout;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign dbg_state = r_state;

`ifdef REG_PARITY_EN
    assign par  = ^r_q;
    assign zero = (r_q == '0);
`endif

endmodule

// File: tb/tb_registro_universal_param.sv
// Directed bench for registro_universal_param (N=8, RST_VAL=0); covers par/zero when REG_PARITY_EN is defined.
module tb_registro_universal_param;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_ASR  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    logic       clk = 1'b0;
    logic       rst, en, sin, start;
    logic [2:0] op;
    logic [7:0] d;
    logic [3:0] amt;
    logic [7:0] q;
    logic       sout, busy, done;
    logic [1:0] dbg_state;
`ifdef REG_PARITY_EN
    logic       par, zero;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    registro_universal_param #(.N(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .d(d), .sin(sin),
        .start(start), .amt(amt), .q(q), .sout(sout), .busy(busy), .done(done),
`ifdef REG_PARITY_EN
        .par(par), .zero(zero),
`endif
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        en = 1'b0; start = 1'b0; op = OP_HOLD; d = 8'h00; amt = 4'd0; sin = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op_i, input logic [7:0] d_i, input logic sin_i);
        en = 1'b1; start = 1'b0; op = op_i; d = d_i; sin = sin_i;
        tick();
        idle_in();
    endtask

    task automatic do_start(input logic [2:0] op_i, input logic [3:0] amt_i, input logic sin_i);
        en = 1'b1; start = 1'b1; op = op_i; amt = amt_i; sin = sin_i;
        tick();
        en = 1'b0; start = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen; expired budget counts as a failure.
    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
            if (busy && done) check("busy_done_overlap", 1, 0);
        end
        check("done_seen", done, 1'b1);
    endtask

    initial begin
        int cyc;
        logic seen;

        // reset with LOAD FF pending
        rst = 1'b1; en = 1'b1; start = 1'b0; op = OP_LOAD; d = 8'hFF; sin = 1'b0; amt = 4'd0;
        tick();
        tick();
        check("rst_q", q, 8'h00);
        check("rst_sout", sout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
`ifdef REG_PARITY_EN
        check("rst_par", par, 1'b0);
        check("rst_zero", zero, 1'b1);
`endif
        rst = 1'b0;
        idle_in();
        tick();

        // single-cycle ops
        do_op(OP_LOAD, 8'hA5, 1'b0);
        check("load_q", q, 8'hA5);
        do_op(OP_SHL, 8'h00, 1'b1);
        check("shl_q", q, 8'h4B);
        check("shl_sout", sout, 1'b1);
        do_op(OP_ROR, 8'h00, 1'b0);
        check("ror_q", q, 8'hA5);
        check("ror_sout", sout, 1'b1);
        do_op(OP_ASR, 8'h00, 1'b0);
        check("asr_q", q, 8'hD2);
        check("asr_sout", sout, 1'b1);
        do_op(OP_HOLD, 8'h00, 1'b0);
        check("hold_q", q, 8'hD2);
        en = 1'b0; op = OP_LOAD; d = 8'h00;
        tick();
        idle_in();
        check("en0_q", q, 8'hD2);
        do_op(OP_CLR, 8'h00, 1'b0);
        check("clr_q", q, 8'h00);
        check("clr_sout_kept", sout, 1'b1);
        do_op(OP_LOAD, 8'hD2, 1'b0);
        do_op(OP_SHR, 8'h00, 1'b0);
        check("shr_q", q, 8'h69);
        check("shr_sout", sout, 1'b0);

        // multi-step ROL by 3
        do_op(OP_LOAD, 8'h81, 1'b0);
        do_start(OP_ROL, 4'd3, 1'b0);
        check("rol3_start_q", q, 8'h81);
        check("rol3_start_busy", busy, 1'b1);
        check("rol3_start_done", done, 1'b0);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h0C);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rol3_step_q", q, exp_q.pop_front());
            check("rol3_busy", busy, (i < 2) ? 1'b1 : 1'b0);
            check("rol3_done", done, (i == 2) ? 1'b1 : 1'b0);
        end
        check("rol3_sout", sout, 1'b0);

        // command presented during DONE is ignored
        en = 1'b1; op = OP_LOAD; d = 8'h3C;
        tick();
        idle_in();
        check("done_ignore_q", q, 8'h0C);
        check("done_ignore_done", done, 1'b0);

        // amt=0 started the cycle right after done
        do_start(OP_SHR, 4'd0, 1'b1);
        check("amt0_done", done, 1'b1);
        check("amt0_busy", busy, 1'b0);
        check("amt0_q", q, 8'h0C);
        tick();
        check("amt0_done_drop", done, 1'b0);

        // ASR by 12 (amt > N) saturates
        do_op(OP_LOAD, 8'h80, 1'b0);
        do_start(OP_ASR, 4'd12, 1'b0);
        wait_done(20, cyc);
        check("asr12_latency", cyc, 12);
        check("asr12_q", q, 8'hFF);
        check("asr12_sout", sout, 1'b1);
        tick();

        // SHR by 9 with sin=1 fills the word
        do_op(OP_LOAD, 8'h00, 1'b0);
        do_start(OP_SHR, 4'd9, 1'b1);
        wait_done(20, cyc);
        check("shr9_latency", cyc, 9);
        check("shr9_q", q, 8'hFF);
        idle_in();
        tick();

        // reset mid-run
        do_op(OP_LOAD, 8'h01, 1'b0);
        do_start(OP_SHL, 4'd6, 1'b0);
        tick();
        tick();
        check("mid_q", q, 8'h04);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_q", q, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_sout", sout, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("midrst_no_done", seen, 1'b0);

        // commands ignored while busy
        do_op(OP_LOAD, 8'h5A, 1'b0);
        do_start(OP_ROR, 4'd4, 1'b0);
        en = 1'b1; start = 1'b1; op = OP_LOAD; d = 8'h3C; amt = 4'd1;
        wait_done(10, cyc);
        check("busy_ign_latency", cyc, 4);
        check("busy_ign_q", q, 8'hA5);
        check("busy_ign_sout", sout, 1'b1);
        idle_in();
        tick();

`ifdef REG_PARITY_EN
        do_op(OP_LOAD, 8'h07, 1'b0);
        check("par_07", par, 1'b1);
        check("zero_07", zero, 1'b0);
        do_op(OP_CLR, 8'h00, 1'b0);
        check("par_clr", par, 1'b0);
        check("zero_clr", zero, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
